uart_tx_fifo: RTL and testbench

- UART transmitter: 8 data bits, 1 start bit, 1 stop bit, no parity by default. Data is sent LSB first.
- A small byte FIFO sits in front of the serializer, so the core logic can queue several bytes without waiting on the line.
- Serves as the TX half of the host serial link, alongside the existing receiver, on the same clock.
- Bit timing matches the receiver: one bit lasts CLKS_PER_BIT clocks.

---
 rtl/uart_tx_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) behind a FIFO_DEPTH-byte queue; first start bit two clocks after the push.
// o_Tx_Ready drops while the queue is full and o_Tx_Ovf flags dropped pushes. Define UART_TX_PARITY_EN to add an even parity bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 27,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Ovf,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done,
  output logic       o_Tx_Serial
);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = PW + 1;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   CLK_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            push, pop;

  state_t          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            bit_end;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic            serial_q, serial_d;
  logic            active_q, active_d;
  logic            done_q, done_d;

  assign o_Tx_Ready  = (count_q != FULL_CNT);
  assign o_Tx_Ovf    = ovf_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;
  assign o_Tx_Serial = serial_q;

  assign push    = i_Tx_DV && o_Tx_Ready;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign bit_end = (clk_cnt_q == CLK_LAST);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    ovf_d    = i_Tx_DV && !o_Tx_Ready;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (pop) begin
          shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
          parity_d = ^mem_q[rd_ptr_q];
`endif
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = S_CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_CLEANUP: state_d = S_IDLE;
      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  // Line, Active and Done are registered from the current state, so they trail it by one clock.
  always_comb begin
    serial_d = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
      end
      S_DATA: begin
        serial_d = shift_q[0];
        active_d = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        serial_d = parity_q;
        active_d = 1'b1;
      end
`endif
      S_STOP:    active_d = 1'b1;
      S_CLEANUP: done_d   = 1'b1;
      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and random stimulus for uart_tx_fifo; an ideal line receiver decodes every frame and scores it against a byte queue.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int CPB   = 27;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv  = 1'b0;
  logic [7:0] byt = 8'h00;
  logic       ready, ovf, active, done, serial;

  int checks = 0;
  int errors = 0;

  logic [7:0]       exp_q[$];
  int               gap_q[$];
  logic [FRAME-1:0] fr;
  bit               in_frame = 0;
  bit               act_ok;
  int               s_idx, idle_cnt, n_frames, done_cnt, ovf_cnt;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv), .i_Tx_Byte(byt),
    .o_Tx_Ready(ready), .o_Tx_Ovf(ovf), .o_Tx_Active(active),
    .o_Tx_Done(done), .o_Tx_Serial(serial)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ideal frame: start 0, eight data bits LSB first, [even parity], stop 1, each exactly CPB samples.
  task automatic check_frame();
    logic [7:0] got, want;
    bit stable;
    stable = 1;
    for (int b = 0; b < NB; b++)
      for (int c = 1; c < CPB; c++)
        if (fr[b*CPB+c] !== fr[b*CPB]) stable = 0;
    for (int i = 0; i < 8; i++) got[i] = fr[(i+1)*CPB];
    chk("bit_timing", 32'(stable), 1);
    chk("stop_bit", 32'(fr[(NB-1)*CPB]), 1);
    chk("active_span", 32'(act_ok), 1);
    chk("active_fall", 32'(active), 0);
    chk("done_after_stop", 32'(done), 1);
    chk("frame_expected", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      chk("data", 32'(got), 32'(want));
`ifdef UART_TX_PARITY_EN
      chk("parity", 32'(fr[(NB-2)*CPB]), 32'(^want));
`endif
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (ovf === 1'b1) ovf_cnt++;
    if (rst) begin
      in_frame = 0;
      idle_cnt = 0;
    end else if (!in_frame) begin
      if (serial === 1'b0) begin
        in_frame = 1;
        fr       = '0;
        s_idx    = 1;
        act_ok   = (active === 1'b1);
        gap_q.push_back(idle_cnt);
        idle_cnt = 0;
        n_frames++;
      end else begin
        idle_cnt++;
      end
    end else if (s_idx < FRAME) begin
      fr[s_idx] = serial;
      if (active !== 1'b1) act_ok = 0;
      s_idx++;
    end else begin
      check_frame();
      in_frame = 0;
      idle_cnt = (serial === 1'b1) ? 1 : 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || active === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 1);
    cyc(3);
  endtask

  initial begin
    int d0, f0, o0, k, n;
    logic [7:0] b;

    // Reset state
    cyc(2);
    chk("rst_serial", 32'(serial), 1);
    chk("rst_active", 32'(active), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_ready", 32'(ready), 1);
    rst = 1'b0;
    cyc(2);

    // Single byte: start bit appears two edges after the push
    d0 = done_cnt;
    dv = 1'b1; byt = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    dv = 1'b0;
    chk("lat_edge_n", 32'(serial), 1);
    @(negedge clk);
    chk("lat_edge_n1", 32'(serial), 1);
    chk("lat_edge_n1_active", 32'(active), 0);
    @(negedge clk);
    chk("lat_edge_n2", 32'(serial), 0);
    chk("lat_edge_n2_active", 32'(active), 1);
    wait_idle(FRAME + 100, "drain_a5");
    chk("done_count_a5", 32'(done_cnt - d0), 1);

    // Burst of four plus one to fill, then overflow while full
    d0 = done_cnt; f0 = n_frames; gap_q.delete();
    for (int i = 1; i <= 4; i++) begin
      dv = 1'b1; byt = 8'(i); exp_q.push_back(8'(i));
      @(negedge clk);
      chk("burst_ready", 32'(ready), 1);
    end
    byt = 8'h05; exp_q.push_back(8'h05);
    @(negedge clk);
    chk("full_ready", 32'(ready), 0);
    chk("full_no_ovf", 32'(ovf), 0);
    k = $urandom_range(3, 6);
    o0 = ovf_cnt;
    byt = 8'hFF;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("ovf_pulse", 32'(ovf), 1);
      chk("ovf_ready", 32'(ready), 0);
    end
    dv = 1'b0;
    @(negedge clk);
    chk("ovf_clear", 32'(ovf), 0);
    chk("ovf_count", 32'(ovf_cnt - o0), 32'(k));
    wait_idle(6 * (FRAME + 10), "drain_burst");
    chk("burst_done_count", 32'(done_cnt - d0), 5);
    chk("burst_frames", 32'(n_frames - f0), 5);
    for (int i = 1; i < 5 && i < gap_q.size(); i++) chk("frame_gap", 32'(gap_q[i]), 2);

    // Reset in data bit 3 of 0x5A with two more bytes queued behind it
    dv = 1'b1; byt = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk);
    byt = 8'h11;
    @(negedge clk);
    byt = 8'h22;
    @(negedge clk);
    dv = 1'b0;
    cyc(4 * CPB + 12);
    chk("mid_bit3_active", 32'(active), 1);
    d0 = done_cnt; f0 = n_frames;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_serial", 32'(serial), 1);
    chk("rst_mid_active", 32'(active), 0);
    chk("rst_mid_ready", 32'(ready), 1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cyc(40);
    chk("rst_no_done", 32'(done_cnt - d0), 0);
    chk("rst_flushed", 32'(n_frames - f0), 0);
    chk("rst_idle_line", 32'(serial), 1);
    dv = 1'b1; byt = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge clk);
    dv = 1'b0;
    wait_idle(FRAME + 100, "drain_3c");
    chk("done_count_3c", 32'(done_cnt - d0), 1);

    // Random bytes with random spacing, pushing only while ready
    d0 = done_cnt; o0 = ovf_cnt;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (ready !== 1'b1 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("ready_wait", 32'(n < 2000), 1);
      b = 8'($urandom_range(255));
      dv = 1'b1; byt = b; exp_q.push_back(b);
      @(negedge clk);
      dv = 1'b0;
      if ($urandom_range(7) == 0) cyc(FRAME + $urandom_range(20));
      else cyc($urandom_range(3));
    end
    wait_idle(45 * (FRAME + 10), "drain_random");
    chk("random_done_count", 32'(done_cnt - d0), 40);
    chk("random_no_ovf", 32'(ovf_cnt - o0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
